// File: rtl/gpio_pkg.sv
// Shared register map and address-width helper for the GPIO bank.
package gpio_pkg;

  typedef enum logic [2:0] {
    REG_OUT       = 3'd0,
    REG_DIR       = 3'd1,
    REG_IN        = 3'd2,
    REG_FLAGS     = 3'd3,
    REG_IRQ_EN    = 3'd4,
    REG_EDGE_MODE = 3'd5,
    REG_TOGGLE    = 3'd6,
    REG_RSVD      = 3'd7
  } reg_e;

  // Address is {channel, 3-bit register index}.
  function automatic int addr_w(input int channels);
    return $clog2(channels) + 3;
  endfunction

endpackage

// File: rtl/gpio_channel.sv
// One GPIO port: OUT/DIR/FLAGS/IRQ_EN/EDGE_MODE registers, 2-flop pin sync,
// previous-value flop and edge-to-flag logic.
module gpio_channel import gpio_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetq,
  input  logic             wr,
  input  reg_e             idx,
  input  logic [WIDTH-1:0] wdata,
  input  logic [WIDTH-1:0] pin_in,
  output logic [WIDTH-1:0] pin_out,
  output logic [WIDTH-1:0] pin_oe,
  output logic [WIDTH-1:0] rd_val,
  output logic             irq_any
);

  logic [WIDTH-1:0] out_r, dir_r, flags, irq_en, edge_mode;
  logic [WIDTH-1:0] sync1, sync2, prev;
  logic [WIDTH-1:0] hit, clr;
  logic [2:0]       vld_pipe;

  // Edge compare is held off until prev carries a post-reset sample, so
  // pad activity from before reset never turns into a flag.
  assign hit = vld_pipe[2] ? ((sync2 & ~prev & ~edge_mode) | (~sync2 & prev & edge_mode))
                           : '0;
  assign clr = (wr && idx == REG_FLAGS) ? wdata : '0;

  always_ff @(posedge clk) begin
    if (resetq) begin
      out_r     <= '0;
      dir_r     <= '0;
      flags     <= '0;
      irq_en    <= '0;
      edge_mode <= '0;
      sync1     <= '0;
      sync2     <= '0;
      prev      <= '0;
      vld_pipe  <= '0;
    end else begin
      sync1    <= pin_in;
      sync2    <= sync1;
      prev     <= sync2;
      vld_pipe <= {vld_pipe[1:0], 1'b1};
      // A new edge beats a same-cycle write-1-to-clear.
      flags    <= (flags & ~clr) | hit;
      if (wr) begin
        case (idx)
          REG_OUT:       out_r     <= wdata;
          REG_DIR:       dir_r     <= wdata;
          REG_IRQ_EN:    irq_en    <= wdata;
          REG_EDGE_MODE: edge_mode <= wdata;
          REG_TOGGLE:    out_r     <= out_r ^ wdata;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rd_val = '0;
    case (idx)
      REG_OUT:       rd_val = out_r;
      REG_DIR:       rd_val = dir_r;
      REG_IN:        rd_val = sync2;
      REG_FLAGS:     rd_val = flags;
      REG_IRQ_EN:    rd_val = irq_en;
      REG_EDGE_MODE: rd_val = edge_mode;
      default:       rd_val = '0;
    endcase
  end

  assign pin_out = out_r;
  assign pin_oe  = dir_r;
  assign irq_any = |(flags & irq_en);

endmodule

// File: rtl/gpio_bank.sv
// Multi-channel GPIO bank: address decode, registered read mux and
// registered interrupt OR over gpio_channel instances.
module gpio_bank import gpio_pkg::*; #(
  parameter  int CHANNELS = 2,
  parameter  int WIDTH    = 8,
  localparam int ADDR_W   = addr_w(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      resetq,
  input  logic                      sel,
  input  logic                      io_write_enable,
  input  logic                      io_read_enable,
  input  logic [ADDR_W-1:0]         reg_addr,
  input  logic [0:15]               io_write_data,
  output logic [0:15]               io_read_data,
  input  logic [CHANNELS*WIDTH-1:0] pin_in,
  output logic [CHANNELS*WIDTH-1:0] pin_out,
  output logic [CHANNELS*WIDTH-1:0] pin_oe,
  output logic                      irq
);

  logic [ADDR_W-1:0]              ch_sel;
  reg_e                           ridx;
  logic                           wr_q, rd_q;
  logic [CHANNELS-1:0][WIDTH-1:0] rd_val;
  logic [CHANNELS-1:0]            ch_irq;
  logic [WIDTH-1:0]               rd_mux;
  logic [15:0]                    rdata;

  assign ch_sel = reg_addr >> 3;
  assign ridx   = reg_e'(reg_addr[2:0]);
  assign wr_q   = sel & io_write_enable;
  assign rd_q   = sel & io_read_enable;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    gpio_channel #(.WIDTH(WIDTH)) u_ch (
      .clk     (clk),
      .resetq  (resetq),
      .wr      (wr_q && ch_sel == ADDR_W'(c)),
      .idx     (ridx),
      .wdata   (io_write_data[16-WIDTH:15]),
      .pin_in  (pin_in[c*WIDTH +: WIDTH]),
      .pin_out (pin_out[c*WIDTH +: WIDTH]),
      .pin_oe  (pin_oe[c*WIDTH +: WIDTH]),
      .rd_val  (rd_val[c]),
      .irq_any (ch_irq[c])
    );
  end

  // Unpopulated channel indices fall through to zero.
  always_comb begin
    rd_mux = '0;
    for (int c = 0; c < CHANNELS; c++)
      if (ch_sel == ADDR_W'(c)) rd_mux = rd_val[c];
  end

  always_ff @(posedge clk) begin
    if (resetq) begin
      rdata <= '0;
      irq   <= 1'b0;
    end else begin
      irq <= |ch_irq;
      if (rd_q) rdata <= 16'(rd_mux);
    end
  end

  assign io_read_data = rdata;

endmodule

// File: tb/tb_gpio_bank.sv
// Self-checking bench for gpio_bank: register vector table with a read
// scoreboard, plus hand sequences for edge/flag/irq/reset timing.
module tb_gpio_bank;

  localparam int CH = 3;  // three channels so channel index 3 is unpopulated
  localparam int W  = 8;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          resetq = 1'b1;
  logic          sel = 1'b0, io_write_enable = 1'b0, io_read_enable = 1'b0;
  logic [AW-1:0] reg_addr = '0;
  logic [0:15]   io_write_data = '0;
  logic [0:15]   io_read_data;
  logic [CH*W-1:0] pin_in = '0, pin_out, pin_oe;
  logic          irq;

  gpio_bank #(.CHANNELS(CH), .WIDTH(W)) dut (
    .clk(clk), .resetq(resetq), .sel(sel), .io_write_enable(io_write_enable),
    .io_read_enable(io_read_enable), .reg_addr(reg_addr),
    .io_write_data(io_write_data), .io_read_data(io_read_data),
    .pin_in(pin_in), .pin_out(pin_out), .pin_oe(pin_oe), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_wr;
    logic [4:0]  addr;
    logic [15:0] data;
    logic [15:0] exp;
    string       name;
  } vec_t;

  typedef struct {
    string       name;
    logic [15:0] exp;
  } sb_t;

  vec_t tbl[$];
  sb_t  sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [15:0] d);
    reg_addr = a; io_write_data = d; sel = 1'b1; io_write_enable = 1'b1;
    tick();
    sel = 1'b0; io_write_enable = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [15:0] e, input string name);
    sb_t s;
    reg_addr = a; sel = 1'b1; io_read_enable = 1'b1;
    sb.push_back('{name, e});
    tick();
    sel = 1'b0; io_read_enable = 1'b0;
    s = sb.pop_front();
    chk(s.name, io_read_data, s.exp);
  endtask

  task automatic add(input bit w, input logic [4:0] a, input logic [15:0] d,
                     input logic [15:0] e, input string n);
    tbl.push_back('{w, a, d, e, n});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    add(0, 5'h00, 0, 16'h00A5, "ch0_out");
    add(0, 5'h01, 0, 16'h00FF, "ch0_dir");
    add(1, 5'h08, 16'h0030, 0, "");
    add(1, 5'h0E, 16'h000F, 0, "");
    add(0, 5'h08, 0, 16'h003F, "ch1_toggle_set");
    add(1, 5'h0E, 16'h000F, 0, "");
    add(0, 5'h08, 0, 16'h0030, "ch1_toggle_back");
    add(0, 5'h0E, 0, 16'h0000, "toggle_reads_zero");
    add(1, 5'h0C, 16'hAB55, 0, "");
    add(0, 5'h0C, 0, 16'h0055, "wide_write_trunc");
    add(1, 5'h0C, 16'h0000, 0, "");
    add(1, 5'h18, 16'h00FF, 0, "");
    add(0, 5'h18, 0, 16'h0000, "unpopulated_ch_read");
    add(1, 5'h0A, 16'h00FF, 0, "");
    add(0, 5'h0A, 0, 16'h0000, "in_write_ignored");
    add(1, 5'h0F, 16'h00FF, 0, "");
    add(0, 5'h0F, 0, 16'h0000, "reserved_reads_zero");
    add(1, 5'h14, 16'h005A, 0, "");
    add(0, 5'h14, 0, 16'h005A, "ch2_irq_en");
    add(1, 5'h14, 16'h0000, 0, "");
    add(0, 5'h00, 0, 16'h00A5, "ch0_out_intact");
    add(0, 5'h08, 0, 16'h0030, "ch1_out_intact");

    // Reset state
    tick(2);
    chk("rst_read_data", io_read_data, 16'h0000);
    chk("rst_irq", 16'(irq), 16'h0000);
    chk("rst_pin_out", 16'(pin_out), 16'h0000);
    chk("rst_pin_oe", 16'(pin_oe), 16'h0000);
    resetq = 1'b0;
    tick(4);

    wr(5'h01, 16'h00FF);
    wr(5'h00, 16'h00A5);
    chk("pin_oe_ch0", 16'(pin_oe[7:0]), 16'h00FF);
    chk("pin_out_ch0", 16'(pin_out[7:0]), 16'h00A5);

    foreach (tbl[i]) begin
      if (tbl[i].is_wr) wr(tbl[i].addr, tbl[i].data);
      else              rd(tbl[i].addr, tbl[i].exp, tbl[i].name);
    end
    chk("pin_out_ch1", 16'(pin_out[15:8]), 16'h0030);
    chk("pin_oe_ch1", 16'(pin_oe[15:8]), 16'h0000);
    chk("irq_idle", 16'(irq), 16'h0000);

    // Read data holds; unselected strobes are ignored
    reg_addr = 5'h00; io_read_enable = 1'b1;
    tick(2);
    io_read_enable = 1'b0;
    chk("rd_hold", io_read_data, 16'h0030);

    // Rising edge on ch0 bit0: flag on 3rd edge, irq one edge later
    wr(5'h04, 16'h0001);
    pin_in[0] = 1'b1;
    tick(2);
    rd(5'h03, 16'h0000, "flag_read_pre_edge");
    chk("irq_lags_flag", 16'(irq), 16'h0000);
    rd(5'h03, 16'h0001, "flag_after_3");
    chk("irq_asserted", 16'(irq), 16'h0001);
    rd(5'h02, 16'h0001, "in_synced");
    wr(5'h03, 16'h0001);
    chk("irq_held_after_clr", 16'(irq), 16'h0001);
    tick();
    chk("irq_cleared", 16'(irq), 16'h0000);

    // Falling mode on bit1
    wr(5'h05, 16'h0002);
    pin_in[1] = 1'b1;
    tick(5);
    rd(5'h03, 16'h0000, "rise_ignored_fall_mode");
    pin_in[1] = 1'b0;
    tick(4);
    rd(5'h03, 16'h0002, "fall_flag");
    chk("irq_masked_by_en", 16'(irq), 16'h0000);
    wr(5'h03, 16'h0000);
    rd(5'h03, 16'h0002, "w0_keeps_flag");
    pin_in[1] = 1'b1;
    tick(4);
    pin_in[1] = 1'b0;
    tick(2);
    wr(5'h03, 16'h0002);  // clear lands on the edge that sets the flag
    rd(5'h03, 16'h0002, "set_beats_w1c");
    wr(5'h03, 16'h0002);
    rd(5'h03, 16'h0000, "w1c_clears");

    // Pending irq, then reset mid-edge on bit2 with a write during reset
    wr(5'h05, 16'h0000);
    pin_in[0] = 1'b0;
    tick(4);
    pin_in[0] = 1'b1;
    tick(5);
    chk("irq_pre_reset", 16'(irq), 16'h0001);
    pin_in[2] = 1'b1;
    tick();
    resetq = 1'b1;
    reg_addr = 5'h00; io_write_data = 16'h00FF; sel = 1'b1; io_write_enable = 1'b1;
    tick();
    sel = 1'b0; io_write_enable = 1'b0;
    tick();
    chk("mid_rst_pin_out", 16'(pin_out), 16'h0000);
    chk("mid_rst_pin_oe", 16'(pin_oe), 16'h0000);
    chk("mid_rst_irq", 16'(irq), 16'h0000);
    chk("mid_rst_read_data", io_read_data, 16'h0000);
    resetq = 1'b0;
    tick(6);
    rd(5'h03, 16'h0000, "no_flag_after_reset");
    rd(5'h00, 16'h0000, "write_in_reset_ignored");
    chk("irq_after_reset", 16'(irq), 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
